// File: rtl/mem_sys_pkg.sv
// Shared types and default sizing for the system-side memory initiator.
package mem_sys_pkg;

  localparam int AW_DEF      = 8;
  localparam int DW_DEF      = 8;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD,
    DONE
  } state_e;

  // MODE_RSVD behaves exactly like MODE_WRITE_ONLY.
  typedef enum logic [1:0] {
    MODE_WRITE_ONLY      = 2'd0,
    MODE_READ_CHECK      = 2'd1,
    MODE_WRITE_THEN_READ = 2'd2,
    MODE_RSVD            = 2'd3
  } mode_e;

endpackage

// File: rtl/mem_sys_if.sv
// Single-beat command bus between the system initiator (master) and the memory controller (slave).
interface mem_sys_if #(
  parameter int AW = mem_sys_pkg::AW_DEF,
  parameter int DW = mem_sys_pkg::DW_DEF
) ();

  logic          we_sys;
  logic          cmd_valid_sys;
  logic [AW-1:0] addr_sys;
  logic [DW-1:0] wdata_sys;
  logic          ready_sys;
  logic [DW-1:0] rdata_sys;

  modport master (
    output we_sys, cmd_valid_sys, addr_sys, wdata_sys,
    input  ready_sys, rdata_sys
  );

  modport slave (
    input  we_sys, cmd_valid_sys, addr_sys, wdata_sys,
    output ready_sys, rdata_sys
  );

endinterface

// File: rtl/mem_pattern_gen.sv
// Combinational burst pattern: data = (addr ^ seed) + beat_idx, all mod 2^DW.
module mem_pattern_gen
  import mem_sys_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic [AW-1:0] addr,
  input  logic [AW:0]   beat_idx,
  input  logic [DW-1:0] seed,
  output logic [DW-1:0] data
);

  logic [DW-1:0] addr_d;
  logic [DW-1:0] idx_d;

  assign addr_d = DW'(addr);
  assign idx_d  = DW'(beat_idx);
  assign data   = (addr_d ^ seed) + idx_d;

endmodule

// File: rtl/mem_sys_initiator.sv
// Self-test initiator: runs a programmed write/read burst against the memory controller,
// checks read data against the pattern and aborts on a stalled controller.
module mem_sys_initiator
  import mem_sys_pkg::*;
#(
  parameter int AW          = AW_DEF,
  parameter int DW          = DW_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   length,
  input  logic [DW-1:0] seed,
  mem_sys_if.master     bus,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   err_cnt,
  output logic [AW-1:0] first_err_addr,
  output logic          timeout
);

  localparam int                WCW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WCW-1:0]    WAIT_LAST = WCW'(TIMEOUT_CYC - 1);
  localparam logic [WCW-1:0]    W_ONE     = WCW'(1);
  localparam logic [AW:0]       B_ONE     = (AW+1)'(1);

  state_e        state;
  logic          wr_then_rd;
  logic [AW-1:0] base_q;
  logic [AW:0]   len_q;
  logic [DW-1:0] seed_q;
  logic [AW:0]   beat_idx;
  logic [WCW-1:0] wait_cnt;

  logic          cmd_valid_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;

  logic [AW-1:0] cur_addr;
  logic [DW-1:0] exp_data;
  logic          last_beat;
  logic          rd_err;

  assign bus.cmd_valid_sys = cmd_valid_q;
  assign bus.we_sys        = we_q;
  assign bus.addr_sys      = addr_q;
  assign bus.wdata_sys     = wdata_q;

  // beat_idx is stable for the whole beat, so the same pattern output serves
  // both the write data at issue time and the read compare at completion.
  assign cur_addr  = base_q + beat_idx[AW-1:0];
  assign last_beat = (beat_idx + B_ONE) == len_q;
  assign rd_err    = (bus.rdata_sys != exp_data);

  mem_pattern_gen #(.AW(AW), .DW(DW)) u_pat (
    .addr     (cur_addr),
    .beat_idx (beat_idx),
    .seed     (seed_q),
    .data     (exp_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      wr_then_rd     <= 1'b0;
      base_q         <= '0;
      len_q          <= '0;
      seed_q         <= '0;
      beat_idx       <= '0;
      wait_cnt       <= '0;
      cmd_valid_q    <= 1'b0;
      we_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
      timeout        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            base_q         <= base_addr;
            len_q          <= length;
            seed_q         <= seed;
            wr_then_rd     <= (mode_e'(mode) == MODE_WRITE_THEN_READ);
            beat_idx       <= '0;
            wait_cnt       <= '0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            timeout        <= 1'b0;
            if (length == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= (mode_e'(mode) == MODE_READ_CHECK) ? RD : WR;
              busy  <= 1'b1;
            end
          end
        end

        WR, RD: begin
          if (!cmd_valid_q) begin
            // Gap cycle after each completed beat: present the next command.
            cmd_valid_q <= 1'b1;
            we_q        <= (state == WR);
            addr_q      <= cur_addr;
            wdata_q     <= (state == WR) ? exp_data : '0;
            wait_cnt    <= '0;
          end else if (bus.ready_sys) begin
            cmd_valid_q <= 1'b0;
            if (state == RD && rd_err) begin
              if (err_cnt == '0)
                first_err_addr <= addr_q;
              if (err_cnt != '1)
                err_cnt <= err_cnt + B_ONE;
            end
            if (last_beat) begin
              if (state == WR && wr_then_rd) begin
                state    <= RD;
                beat_idx <= '0;
              end else begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              beat_idx <= beat_idx + B_ONE;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            cmd_valid_q <= 1'b0;
            timeout     <= 1'b1;
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + W_ONE;
          end
        end

        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_sys_initiator.sv
// Scoreboard bench: a memory slave with random latency sits on the bus, a spec-level
// model predicts the command stream and end-of-burst status, a monitor compares them.
module tb_mem_sys_initiator;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [1:0] mode = '0;
  logic [7:0] base_addr = '0;
  logic [8:0] length = '0;
  logic [7:0] seed = '0;
  logic       busy, done, timeout;
  logic [8:0] err_cnt;
  logic [7:0] first_err_addr;

  mem_sys_if #(.AW(8), .DW(8)) bus ();

  mem_sys_initiator #(.AW(8), .DW(8), .TIMEOUT_CYC(64)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .mode           (mode),
    .base_addr      (base_addr),
    .length         (length),
    .seed           (seed),
    .bus            (bus),
    .busy           (busy),
    .done           (done),
    .err_cnt        (err_cnt),
    .first_err_addr (first_err_addr),
    .timeout        (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
  } cmd_t;

  typedef struct {
    int         err;
    logic [7:0] first;
    logic       tmo;
  } st_t;

  cmd_t       cmd_q[$];
  st_t        st_q[$];
  logic [7:0] ref_mem [256];
  logic [7:0] slv_mem [256];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         done_cnt = 0;
  int         slv_hs = 0;
  int         slv_stall_idx = -1;

  function automatic logic [7:0] pat(input logic [7:0] a, input int i, input logic [7:0] s);
    return (a ^ s) + i[7:0];
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] v);
    ref_mem[a] = v;
    slv_mem[a] = v;
  endtask

  // Memory slave: random 0-5 cycle ready latency, optional never-ready beat,
  // spurious ready pulses while no command is pending.
  initial begin
    int dly;
    dly = -1;
    bus.ready_sys = 1'b0;
    bus.rdata_sys = '0;
    forever begin
      @(negedge clk);
      bus.ready_sys = 1'b0;
      if (reset || !bus.cmd_valid_sys) begin
        dly = -1;
        if (!reset && $urandom_range(0, 3) == 0) begin
          bus.ready_sys = 1'b1;
          bus.rdata_sys = 8'($urandom);
        end
      end else begin
        if (dly < 0) dly = (slv_hs == slv_stall_idx) ? 1000000 : int'($urandom_range(0, 5));
        if (dly == 0) begin
          bus.ready_sys = 1'b1;
          if (bus.we_sys) slv_mem[bus.addr_sys] = bus.wdata_sys;
          else            bus.rdata_sys = slv_mem[bus.addr_sys];
          slv_hs++;
          dly = -1;
        end else begin
          dly--;
        end
      end
    end
  end

  // Monitor: checks every accepted command, command hold while waiting, and burst status on done.
  initial begin
    cmd_t       e;
    st_t        s;
    logic       pv, pr, pd, pwe;
    logic [7:0] pa, pw;
    pv = 0; pr = 0; pd = 0; pwe = 0; pa = 0; pw = 0;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        pv = 0;
        pd = 0;
      end else begin
        if (pv && !pr && bus.cmd_valid_sys)
          chk("cmd_hold", {bus.we_sys, bus.addr_sys, bus.wdata_sys}, {pwe, pa, pw});
        if (bus.cmd_valid_sys && bus.ready_sys) begin
          if (cmd_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_cmd: got we=%0d addr=0x%0h, expected no command",
                     bus.we_sys, bus.addr_sys);
          end else begin
            e = cmd_q.pop_front();
            chk("cmd_we", bus.we_sys, e.we);
            chk("cmd_addr", bus.addr_sys, e.addr);
            if (e.we) chk("cmd_wdata", bus.wdata_sys, e.data);
          end
        end
        if (done) begin
          chk("done_one_cycle", pd, 0);
          done_cnt++;
          if (st_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1, expected no burst end");
          end else begin
            s = st_q.pop_front();
            chk("err_cnt", err_cnt, s.err);
            chk("first_err_addr", first_err_addr, s.first);
            chk("timeout", timeout, s.tmo);
            chk("busy_at_done", busy, 0);
            chk("valid_at_done", bus.cmd_valid_sys, 0);
            chk("beats_missing", cmd_q.size(), 0);
          end
        end
        pv = bus.cmd_valid_sys; pr = bus.ready_sys; pd = done;
        pwe = bus.we_sys; pa = bus.addr_sys; pw = bus.wdata_sys;
      end
    end
  end

  // Predict the burst from the pattern/addressing rules, then drive it.
  task automatic run_burst(input int md, input int base, input int len, input int sd,
                           input int stall, input bit glitch);
    bit         wr, rd, stop;
    int         n, err, d0, cyc;
    logic [7:0] first, a, p;
    cmd_t       c;
    st_t        s;
    wr = (md != 1);
    rd = (md == 1 || md == 2);
    n = 0; err = 0; first = 0; stop = 0;
    if (wr)
      for (int i = 0; i < len && !stop; i++) begin
        if (n == stall) stop = 1;
        else begin
          a = 8'(base + i);
          p = pat(a, i, 8'(sd));
          c.we = 1; c.addr = a; c.data = p;
          cmd_q.push_back(c);
          ref_mem[a] = p;
          n++;
        end
      end
    if (rd && !stop)
      for (int i = 0; i < len && !stop; i++) begin
        if (n == stall) stop = 1;
        else begin
          a = 8'(base + i);
          p = pat(a, i, 8'(sd));
          c.we = 0; c.addr = a; c.data = p;
          cmd_q.push_back(c);
          if (ref_mem[a] != p) begin
            if (err == 0) first = a;
            if (err < 511) err++;
          end
          n++;
        end
      end
    s.err = err; s.first = first; s.tmo = stop;
    st_q.push_back(s);
    slv_stall_idx = stall;
    slv_hs = 0;
    @(negedge clk);
    start = 1; mode = 2'(md); base_addr = 8'(base); length = 9'(len); seed = 8'(sd);
    @(negedge clk);
    start = 0;
    d0 = done_cnt;
    cyc = 0;
    while (done_cnt == d0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (glitch && cyc == 3) begin
        start = 1; mode = ~mode; base_addr = ~base_addr; length = 9'(len + 7); seed = ~seed;
      end else begin
        start = 0;
      end
    end
    chk("done_seen", done_cnt != d0, 1);
    start = 0;
    slv_stall_idx = -1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int         cyc;
    logic [7:0] a;
    cmd_t       c;
    st_t        s;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = '0;
      slv_mem[i] = '0;
    end
    #2 reset = 1;
    #1;
    chk("rst_valid", bus.cmd_valid_sys, 0);
    chk("rst_we", bus.we_sys, 0);
    chk("rst_addr", bus.addr_sys, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_timeout", timeout, 0);
    repeat (3) @(negedge clk);
    reset = 0;
    repeat (2) @(negedge clk);

    // Write-then-read, clean memory path.
    run_burst(2, 'h10, 4, 'hA5, -1, 0);
    // Read check: 0x20 holds the right pattern, 0x21 does not.
    preload(8'h20, pat(8'h20, 0, 8'h00));
    preload(8'h21, 8'h00);
    run_burst(1, 'h20, 2, 'h00, -1, 0);
    // Address wrap.
    run_burst(0, 'hFE, 4, 'h3C, -1, 0);
    // Controller stall on beat 2.
    run_burst(0, 'h30, 5, 'h11, 2, 0);
    // Start while busy is ignored.
    run_burst(2, 'h80, 6, 'h5A, -1, 1);
    // Reserved mode behaves as write-only.
    run_burst(3, 'hC0, 3, 'h77, -1, 0);

    // Reset during beat 1 of a write burst.
    a = 8'h40;
    c.we = 1; c.addr = a; c.data = pat(a, 0, 8'h3C);
    cmd_q.push_back(c);
    ref_mem[a] = c.data;
    slv_stall_idx = 1;
    slv_hs = 0;
    @(negedge clk);
    start = 1; mode = 0; base_addr = a; length = 9'd4; seed = 8'h3C;
    @(negedge clk);
    start = 0;
    cyc = 0;
    while (!(slv_hs == 1 && bus.cmd_valid_sys) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("beat1_reached", slv_hs == 1 && bus.cmd_valid_sys, 1);
    @(negedge clk);
    reset = 1;
    #1;
    chk("mid_rst_valid", bus.cmd_valid_sys, 0);
    chk("mid_rst_bus", {bus.we_sys, bus.addr_sys, bus.wdata_sys}, 0);
    chk("mid_rst_status", {busy, done, timeout, err_cnt, first_err_addr}, 0);
    @(negedge clk);
    reset = 0;
    slv_stall_idx = -1;
    chk("mid_rst_beats", cmd_q.size(), 0);
    cmd_q.delete();
    s.err = 0; s.first = 0; s.tmo = 0;
    st_q.push_back(s);
    @(negedge clk);
    start = 1; mode = 0; base_addr = 8'h55; length = '0; seed = 8'h00;
    @(negedge clk);
    start = 0;
    #1;
    chk("len0_done", done, 1);
    repeat (4) @(negedge clk);
    chk("len0_no_cmd", bus.cmd_valid_sys, 0);

    // Randomized bursts.
    for (int k = 0; k < 30; k++) begin
      int md, base, len, sd, tot, stall;
      bit gl;
      md   = int'($urandom_range(0, 3));
      base = int'($urandom_range(0, 255));
      len  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 20));
      sd   = int'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1)
        for (int j = 0; j < 4; j++) preload(8'($urandom), 8'($urandom));
      tot   = (md == 2) ? 2 * len : len;
      stall = (tot > 0 && $urandom_range(0, 5) == 0) ? int'($urandom_range(0, tot - 1)) : -1;
      gl    = (tot >= 4) && ($urandom_range(0, 2) == 0);
      run_burst(md, base, len, sd, stall, gl);
    end

    repeat (4) @(negedge clk);
    chk("cmd_q_drained", cmd_q.size(), 0);
    chk("st_q_drained", st_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
